// File: rtl/wb_arb_rr.sv
// Two-master to one-slave Wishbone arbiter with round-robin grant on contention
// and a watchdog that force-terminates strobes the slave never acknowledges.
//
// state | meaning
// IDLE  | no owner; slave cyc/stb low, slave address/data path shows m0
// OWN0  | m0 owns the slave path until it drops m0_cyc_i
// OWN1  | m1 owns the slave path until it drops m1_cyc_i
module wb_arb_rr #(
  parameter int unsigned timeout     = 255,
  parameter int unsigned tmo_count_w = 8
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic [31:0]            m0_adr_i,
  input  logic [31:0]            m0_dat_i,
  output logic [31:0]            m0_dat_o,
  input  logic [3:0]             m0_sel_i,
  input  logic                   m0_we_i,
  input  logic                   m0_cyc_i,
  input  logic                   m0_stb_i,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,

  input  logic [31:0]            m1_adr_i,
  input  logic [31:0]            m1_dat_i,
  output logic [31:0]            m1_dat_o,
  input  logic [3:0]             m1_sel_i,
  input  logic                   m1_we_i,
  input  logic                   m1_cyc_i,
  input  logic                   m1_stb_i,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,

  output logic [31:0]            s_adr_o,
  output logic [31:0]            s_dat_o,
  input  logic [31:0]            s_dat_i,
  output logic [3:0]             s_sel_o,
  output logic                   s_we_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  input  logic                   s_ack_i,

  output logic [1:0]             grant_o,
  output logic                   tmo_irq_o,
  output logic [tmo_count_w-1:0] tmo_count_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  // A disabled watchdog still gets a 1-bit counter so the vectors stay legal.
  localparam int unsigned     WD_W     = (timeout > 0) ? $clog2(timeout + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(timeout);
  localparam logic            TMO_EN   = (timeout != 0);

  logic [1:0]             state_q, state_d;
  logic                   last_q, last_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   irq_q, irq_d;
  logic [tmo_count_w-1:0] cnt_q, cnt_d;

  logic own;
  logic sel1;
  logic cyc_own;
  logic stb_own;
  logic tmo_evt;
  logic granting;

  assign own     = (state_q == OWN0) || (state_q == OWN1);
  assign sel1    = (state_q == OWN1);
  assign cyc_own = sel1 ? m1_cyc_i : m0_cyc_i;
  assign stb_own = sel1 ? m1_stb_i : m0_stb_i;

  assign s_adr_o = sel1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = sel1 ? m1_dat_i : m0_dat_i;
  assign s_sel_o = sel1 ? m1_sel_i : m0_sel_i;
  assign s_we_o  = sel1 ? m1_we_i  : m0_we_i;

  // An ack landing on the limit cycle wins over the timeout.
  assign tmo_evt = TMO_EN && own && cyc_own && (wd_q == WD_LIMIT) && !s_ack_i;

  assign s_cyc_o = own && cyc_own;
  assign s_stb_o = own && stb_own && !tmo_evt;

  assign m0_ack_o = s_ack_i && s_stb_o && (state_q == OWN0);
  assign m1_ack_o = s_ack_i && s_stb_o && (state_q == OWN1);
  assign m0_err_o = tmo_evt && (state_q == OWN0);
  assign m1_err_o = tmo_evt && (state_q == OWN1);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign grant_o     = {state_q == OWN1, state_q == OWN0};
  assign tmo_irq_o   = irq_q;
  assign tmo_count_o = cnt_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_d = OWN0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign granting = (state_d != state_q) && ((state_d == OWN0) || (state_d == OWN1));

  always_comb begin
    wd_d = wd_q;
    if (!TMO_EN || granting || s_ack_i || tmo_evt) begin
      wd_d = '0;
    end else if (s_stb_o) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_comb begin
    irq_d = tmo_evt;
    cnt_d = cnt_q;
    if (tmo_evt && (cnt_q != {tmo_count_w{1'b1}})) begin
      cnt_d = cnt_q + tmo_count_w'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
      irq_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      irq_q   <= irq_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arb_rr.sv
// Bench for wb_arb_rr: directed scenarios plus random traffic, every cycle
// compared against a behavioural owner/wait-count model.
module tb_wb_arb_rr;

  localparam int TMO = 16;

  logic        clk, rst;
  logic [31:0] m0_adr, m1_adr, m0_wdat, m1_wdat, s_rdat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb, s_ack;

  logic [31:0] m0_rdat, m1_rdat, s_adr, s_wdat;
  logic [3:0]  s_sel;
  logic        m0_ack, m1_ack, m0_err, m1_err, s_we, s_cyc, s_stb, irq;
  logic [1:0]  grant;
  logic [7:0]  cnt;

  logic [31:0] nt_m0_rdat, nt_m1_rdat, nt_s_adr, nt_s_wdat;
  logic [3:0]  nt_s_sel;
  logic        nt_m0_ack, nt_m1_ack, nt_m0_err, nt_m1_err, nt_s_we, nt_s_cyc, nt_s_stb, nt_irq;
  logic [1:0]  nt_grant;
  logic [7:0]  nt_cnt;

  wb_arb_rr #(.timeout(TMO), .tmo_count_w(8)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_sel_i(m0_sel),
    .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_sel_i(m1_sel),
    .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_ack_i(s_ack),
    .grant_o(grant), .tmo_irq_o(irq), .tmo_count_o(cnt)
  );

  // Same traffic into an instance with the watchdog disabled.
  wb_arb_rr #(.timeout(0), .tmo_count_w(8)) dut_nt (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(nt_m0_rdat), .m0_sel_i(m0_sel),
    .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(nt_m0_ack), .m0_err_o(nt_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(nt_m1_rdat), .m1_sel_i(m1_sel),
    .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(nt_m1_ack), .m1_err_o(nt_m1_err),
    .s_adr_o(nt_s_adr), .s_dat_o(nt_s_wdat), .s_dat_i(s_rdat), .s_sel_o(nt_s_sel), .s_we_o(nt_s_we),
    .s_cyc_o(nt_s_cyc), .s_stb_o(nt_s_stb), .s_ack_i(s_ack),
    .grant_o(nt_grant), .tmo_irq_o(nt_irq), .tmo_count_o(nt_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert, n_fail;

  // Model: owner 0 = none, 1 = m0, 2 = m1; wait = strobe cycles since grant/ack.
  int m_owner, m_last, m_wait, m_cnt;
  bit m_irq;
  int p_ack, p_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_last  = 1;
    m_wait  = 0;
    m_irq   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic idle_inputs();
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // Compare one cycle against the model at the falling edge, then advance the model.
  task automatic step();
    int   own, nxt, other;
    logic cycn, stbn, evt, exp_stb, ocyc;
    @(negedge clk);
    own     = m_owner;
    cycn    = (own == 1) ? m0_cyc : (own == 2) ? m1_cyc : 1'b0;
    stbn    = (own == 1) ? m0_stb : (own == 2) ? m1_stb : 1'b0;
    evt     = (TMO != 0) && (own != 0) && cycn && (m_wait == TMO) && !s_ack;
    exp_stb = (own != 0) && stbn && !evt;
    chk("grant", grant, (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00);
    chk("s_cyc_stb", {s_cyc, s_stb}, {(own != 0) && cycn, exp_stb});
    chk("s_adr", s_adr, (own == 2) ? m1_adr : m0_adr);
    chk("s_wdat", s_wdat, (own == 2) ? m1_wdat : m0_wdat);
    chk("s_sel_we", {s_sel, s_we}, (own == 2) ? {m1_sel, m1_we} : {m0_sel, m0_we});
    chk("m_rdat", {m1_rdat, m0_rdat}, {s_rdat, s_rdat});
    chk("ack_err", {m1_err, m0_err, m1_ack, m0_ack},
        {evt && own == 2, evt && own == 1, s_ack && exp_stb && own == 2, s_ack && exp_stb && own == 1});
    chk("irq_cnt", {irq, cnt}, {m_irq, 8'(m_cnt)});
    chk("nt_quiet", {nt_m1_err, nt_m0_err, nt_irq, nt_cnt}, 64'd0);

    nxt = own;
    if (own == 0) begin
      if (m0_cyc && m1_cyc) nxt = (m_last == 1) ? 1 : 2;
      else if (m0_cyc)      nxt = 1;
      else if (m1_cyc)      nxt = 2;
    end else if (!cycn) begin
      m_last = own - 1;
      other  = 3 - own;
      ocyc   = (other == 1) ? m0_cyc : m1_cyc;
      nxt    = ocyc ? other : 0;
    end
    if ((nxt != 0 && nxt != own) || s_ack || evt) m_wait = 0;
    else if (exp_stb)                            m_wait++;
    m_irq = evt;
    if (evt && m_cnt < 255) m_cnt++;
    m_owner = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    if (m0_cyc) begin
      if ($urandom_range(p_drop - 1) == 0) m0_cyc = 1'b0;
    end else if ($urandom_range(3) == 0) m0_cyc = 1'b1;
    if (m1_cyc) begin
      if ($urandom_range(p_drop - 1) == 0) m1_cyc = 1'b0;
    end else if ($urandom_range(3) == 0) m1_cyc = 1'b1;
    m0_stb  = m0_cyc && ($urandom_range(3) != 0);
    m1_stb  = m1_cyc && ($urandom_range(3) != 0);
    m0_adr  = $urandom;  m1_adr  = $urandom;
    m0_wdat = $urandom;  m1_wdat = $urandom;
    m0_sel  = 4'($urandom); m1_sel = 4'($urandom);
    m0_we   = 1'($urandom); m1_we  = 1'($urandom);
    s_rdat  = $urandom;
    s_ack   = ($urandom_range(p_ack - 1) == 0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0;
    m0_adr = '0; m1_adr = '0; m0_wdat = '0; m1_wdat = '0; s_rdat = '0;
    m0_sel = '0; m1_sel = '0; m0_we = 1'b0; m1_we = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_slave", {s_cyc, s_stb, m1_ack, m0_ack, m1_err, m0_err}, 6'b0);
    chk("rst_irq_cnt", {irq, cnt}, 9'd0);

    // single m0 transfer, ack two cycles after the first strobe
    m0_adr = 32'h8000_0004; m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    chk("t1_req_grant", grant, 2'b00);
    step();
    chk("t1_grant", grant, 2'b01);
    chk("t1_adr", s_adr, 32'h8000_0004);
    chk("t1_no_ack", {m1_ack, m0_ack}, 2'b00);
    step();
    step();
    s_ack = 1'b1;
    #1;
    chk("t1_ack", {m1_ack, m0_ack}, 2'b01);
    step();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    chk("t1_ack_once", {m1_ack, m0_ack}, 2'b00);
    step();
    chk("t1_idle", grant, 2'b00);

    // contention and round-robin alternation with no idle bubble
    reset_dut();
    m1_adr = 32'h1234_5678;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    chk("t2_first", grant, 2'b01);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      else            begin m1_cyc = 1'b0; m1_stb = 1'b0; end
      step();
      chk("t2_handover", grant, (k % 2 == 0) ? 2'b10 : 2'b01);
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      step();
      chk("t2_hold", grant, (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    idle_inputs();
    step();

    // random traffic: busy slave, then a mostly hung slave
    p_ack = 3; p_drop = 8;
    repeat (1500) begin drive_rand(); step(); end
    p_ack = 40; p_drop = 32;
    repeat (1500) begin drive_rand(); step(); end
    idle_inputs();
    step();

    // m1 strobes into a slave that never acks
    reset_dut();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    for (int i = 1; i <= 17; i++) begin
      if (i < 17) chk("t3_wait", {m1_err, s_stb}, 2'b01);
      else begin
        chk("t3_err", {m1_err, s_stb}, 2'b10);
        chk("t3_irq_late", irq, 1'b0);
      end
      step();
    end
    chk("t3_irq", irq, 1'b1);
    chk("t3_cnt", cnt, 8'd1);
    chk("t3_grant_kept", {grant, m1_err, s_stb}, 4'b1001);

    // ack arriving on the limit cycle wins
    for (int i = 1; i <= 16; i++) step();
    s_ack = 1'b1;
    #1;
    chk("t4_ack_wins", {m1_err, m1_ack}, 2'b01);
    step();
    s_ack = 1'b0;
    #1;
    chk("t4_no_irq", {irq, cnt}, {1'b0, 8'd1});

    // 300 more timeouts saturate the counter; disabled watchdog never fires
    repeat (300 * 17) step();
    chk("t5_sat", cnt, 8'hff);
    chk("t5_nt", {nt_m1_err, nt_cnt}, 9'd0);

    // asynchronous reset while m1 owns and is being acked
    s_ack = 1'b1;
    #1;
    chk("t6_pre", {grant, s_cyc, m1_ack}, 4'b1011);
    rst = 1'b0;
    #1;
    chk("t6_async", {grant, s_cyc, m1_ack}, 4'b0000);
    chk("t6_async_cnt", {irq, cnt}, 9'd0);
    model_reset();
    #1;
    rst = 1'b1;
    s_ack = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    chk("t6_contend", grant, 2'b01);
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arb_rr.md
Name: wb_arb_rr

Overview:
- Two-master to one-slave Wishbone arbiter with round-robin grant and a bus watchdog.
- Shares a single slave path between the LM32 instruction and data masters, for example in front of a slow peripheral or external memory.
- The watchdog force-terminates transactions the slave never acks, so a hung peripheral cannot stall the CPU.

Parameters:
- timeout, 255: cycles a granted strobe may wait for s_ack_i before forced termination. 0 disables the watchdog.
- tmo_count_w, 8: width of the saturating timeout event counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- m0_adr_i / m1_adr_i  in  32  master address
- m0_dat_i / m1_dat_i  in  32  master write data
- m0_dat_o / m1_dat_o  out  32  read data (both driven from s_dat_i)
- m0_sel_i / m1_sel_i  in  4  byte select
- m0_we_i / m1_we_i  in  1  write enable
- m0_cyc_i / m1_cyc_i  in  1  cycle, used as the request
- m0_stb_i / m1_stb_i  in  1  strobe
- m0_ack_o / m1_ack_o  out  1  acknowledge
- m0_err_o / m1_err_o  out  1  timeout error termination
- s_adr_o  out  32  slave address
- s_dat_o  out  32  slave write data
- s_dat_i  in  32  slave read data
- s_sel_o  out  4  slave byte select
- s_we_o  out  1  slave write enable
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_ack_i  in  1  slave acknowledge
- grant_o  out  2  one-hot current owner; 00 when idle
- tmo_irq_o  out  1  one-cycle pulse per timeout event
- tmo_count_o  out  tmo_count_w  saturating count of timeout events

Behaviour:
- Reset (rst low, asynchronous) forces, immediately and regardless of any transaction in flight:
  - state=IDLE, grant_o=00, s_cyc_o=s_stb_o=0, all m*_ack_o/m*_err_o=0
  - tmo_irq_o=0, tmo_count_o=0, watchdog counter=0
  - last-served register = m1, so m0 wins the first contention
- States are IDLE, OWN0 and OWN1, all registered.
- IDLE:
  - only m0_cyc_i: go to OWN0.
  - only m1_cyc_i: go to OWN1.
  - both: grant the master that is not last-served.
  - Grant is visible one cycle after the request, so arbitration latency is 1 clock.
- OWNn:
  - s_adr/dat/sel/we/cyc/stb are combinationally muxed from master n.
  - The non-owner sees ack=0 and err=0 and simply waits.
  - Grant is held while mn_cyc_i=1, including back-to-back strobes and bursts.
- Release: in OWNn, when mn_cyc_i=0, last-served becomes n. In the same cycle:
  - other master's cyc=1: next state is OWN(other), with no idle bubble.
  - otherwise: next state is IDLE.
- In IDLE, s_cyc_o=s_stb_o=0 and s_adr/dat/sel/we are driven from m0.
- Ack routing: mn_ack_o = s_ack_i & s_stb_o & (state==OWNn), combinational with zero added latency. s_ack_i in IDLE is ignored.
- Watchdog counter (width clog2(timeout+1)):
  - Cleared on grant and on any cycle with s_ack_i=1.
  - Otherwise increments each OWN cycle with s_stb_o=1.
- Timeout event occurs when timeout!=0, counter==timeout, and s_ack_i=0 in that cycle. On the event:
  - mn_err_o=1 for that cycle and s_stb_o is masked to 0 for that cycle.
  - Counter is cleared.
  - tmo_irq_o pulses high the next cycle.
  - tmo_count_o increments and saturates at all-ones.
- Ack and timeout in the same cycle: ack wins; no err, no irq.
- ack and err are never both high for a master.
- After an err, grant is retained until the owner drops cyc.
- A master that drops cyc mid-wait releases the grant normally; the counter is cleared by the next grant.

Test Plan:
- Reset, then m0_cyc=m0_stb=1 with adr 0x80000004, and slave acks 2 cycles after stb → grant_o=01 one cycle after request; s_adr_o=0x80000004; m0_ack_o high for exactly 1 cycle; m1_ack_o stays 0.
- m0 and m1 request in the same cycle from IDLE after reset → m0 granted first. m0 drops cyc → grant_o goes 01→10 on the next clock with no IDLE cycle. Repeat contention → owners alternate m0, m1, m0, m1.
- timeout=16, m1 strobe with slave never acking → m1_err_o high exactly at the 17th stb cycle with s_stb_o=0 that cycle; tmo_irq_o pulses the following cycle; tmo_count_o=1.
- timeout=16, slave ack lands on the same cycle the counter reaches 16 → m1_ack_o=1, m1_err_o=0, no irq, tmo_count_o unchanged.
- Force 300 timeouts with tmo_count_w=8 → tmo_count_o saturates at 255. Any timeout with timeout=0 → never err.
- Assert rst low mid-transfer while OWN1 waits for ack → s_cyc_o, grant_o and m1_ack_o go 0 without a clock edge. After release, m0 and m1 contend → m0 granted.
